dct_frame_buffer: RTL and testbench

// - Upstream stage of the per-coefficient DCT slices (dct_z0..dct_z7). Accepts a serial stream of
//   8-bit EEG samples over a valid/ready handshake and packs them into 8-sample frames.
// - Ping-pong double buffer: one bank fills while the other is presented in parallel on input0..input7,

---
 rtl/dct_frame_buffer.sv | 162 ++++++++++++++++
 tb/tb_dct_frame_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_frame_buffer.sv
// rtl/dct_frame_buffer.sv - ping-pong 8-sample framer feeding the DCT slices with en/cs compute window
// Optional feature macro: FRAMER_OFFSET_BIN_EN (offset-binary sample capture).
module dct_frame_buffer #(
    parameter int DATA_W     = 8,
    parameter int DCT_CYCLES = 10,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     s_ready,
    output logic signed [DATA_W-1:0] input0,
    output logic signed [DATA_W-1:0] input1,
    output logic signed [DATA_W-1:0] input2,
    output logic signed [DATA_W-1:0] input3,
    output logic signed [DATA_W-1:0] input4,
    output logic signed [DATA_W-1:0] input5,
    output logic signed [DATA_W-1:0] input6,
    output logic signed [DATA_W-1:0] input7,
    output logic                     en,
    output logic                     cs,
    output logic                     frame_start,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0]       CNT_LOAD  = 8'(DCT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  bank_q [2][8];
    logic [DATA_W-1:0]  bank_d [2][8];
    logic [1:0]         full_q, full_d;
    logic               fill_bank_q, fill_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [2:0]         wr_idx_q, wr_idx_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]  lane_q [8];
    logic [DATA_W-1:0]  lane_d [8];
    logic               frame_start_q, frame_start_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic [DATA_W-1:0]  sample_in;
    logic               accept;

`ifdef FRAMER_OFFSET_BIN_EN
    assign sample_in = {~s_data[DATA_W-1], s_data[DATA_W-2:0]};
`else
    assign sample_in = s_data;
`endif

    // Backpressure only when neither bank can take a sample; no sample is ever dropped.
    assign s_ready = ~(full_q[0] & full_q[1]);
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_d       = state_q;
        bank_d        = bank_q;
        full_d        = full_q;
        fill_bank_d   = fill_bank_q;
        rd_bank_d     = rd_bank_q;
        wr_idx_d      = wr_idx_q;
        cnt_d         = cnt_q;
        lane_d        = lane_q;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        if (accept) begin
            bank_d[fill_bank_q][wr_idx_q] = sample_in;
            if (wr_idx_q == 3'd7) begin
                full_d[fill_bank_q] = 1'b1;
                fill_bank_d         = ~fill_bank_q;
                wr_idx_d            = 3'd0;
            end else begin
                wr_idx_d = wr_idx_q + 3'd1;
            end
        end

        // Banks complete in fill order, so the read pointer simply alternates.
        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    for (int i = 0; i < 8; i++) begin
                        lane_d[i] = bank_q[rd_bank_q][i];
                    end
                    frame_start_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + CNT_ONE;
                    cnt_d         = CNT_LOAD;
                    state_d       = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == 8'd0) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    state_d           = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            full_q        <= 2'b00;
            fill_bank_q   <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_idx_q      <= 3'd0;
            cnt_q         <= 8'd0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            full_q        <= full_d;
            fill_bank_q   <= fill_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_idx_q      <= wr_idx_d;
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            lane_q        <= lane_d;
        end
    end

    // Bank contents are qualified by the full flags, so they need no reset.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    assign input0      = lane_q[0];
    assign input1      = lane_q[1];
    assign input2      = lane_q[2];
    assign input3      = lane_q[3];
    assign input4      = lane_q[4];
    assign input5      = lane_q[5];
    assign input6      = lane_q[6];
    assign input7      = lane_q[7];
    assign en          = (state_q == ST_RUN);
    assign cs          = en;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_dct_frame_buffer.sv
// tb/tb_dct_frame_buffer.sv - scoreboard bench for dct_frame_buffer
module tb_dct_frame_buffer;

    localparam int DATA_W     = 8;
    localparam int DCT_CYCLES = 10;
    localparam int CNT_W      = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_ready;
    logic signed [DATA_W-1:0] input0, input1, input2, input3, input4, input5, input6, input7;
    logic              en, cs, frame_start, busy;
    logic [CNT_W-1:0]  frame_cnt;

    dct_frame_buffer #(.DATA_W(DATA_W), .DCT_CYCLES(DCT_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .input0(input0), .input1(input1), .input2(input2), .input3(input3),
        .input4(input4), .input5(input5), .input6(input6), .input7(input7),
        .en(en), .cs(cs), .frame_start(frame_start), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [63:0] exp_q[$];
    logic [63:0] cur_frame;
    int          cur_n = 0;
    int          exp_cnt = 0;
    int          fs_cyc[$];
    bit          mon_skip = 1'b1;
    bit          have_prev = 1'b0;
    bit          chg = 1'b0;
    int          en_len = 0;
    logic [63:0] last_lanes;

    function automatic logic [7:0] exp_of(input logic [7:0] d);
`ifdef FRAMER_OFFSET_BIN_EN
        return {~d[7], d[6:0]};
`else
        return d;
`endif
    endfunction

    function automatic logic [63:0] lanes_now();
        return {input7, input6, input5, input4, input3, input2, input1, input0};
    endfunction

    // Frame monitor: pops expected frames, checks counter, en window length and lane stability.
    always @(negedge clk) begin
        logic [63:0] e;
        if (frame_start === 1'b1) begin
            fs_cyc.push_back(cyc);
            exp_cnt = (exp_cnt + 1) % 16;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL frame_unexpected: lanes=%h, no frame expected", lanes_now());
            end else begin
                e = exp_q.pop_front();
                if (lanes_now() !== e) $display("FAIL frame_lanes: got %h want %h", lanes_now(), e);
                else pass_cnt++;
            end
            total_cnt++;
            if (frame_cnt !== 4'(exp_cnt)) $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, exp_cnt);
            else pass_cnt++;
            total_cnt++;
            if (en !== 1'b1 || cs !== 1'b1) $display("FAIL en_cs_at_start: en=%b cs=%b want 1/1", en, cs);
            else pass_cnt++;
            if (have_prev && !mon_skip) begin
                total_cnt++;
                if (chg) $display("FAIL lanes_stable: lanes changed between frame_start pulses (got 1 want 0)");
                else pass_cnt++;
            end
            mon_skip   = 1'b0;
            have_prev  = 1'b1;
            chg        = 1'b0;
            last_lanes = lanes_now();
        end else if (have_prev && lanes_now() !== last_lanes) begin
            chg = 1'b1;
        end
        if (en === 1'b1) begin
            en_len++;
        end else if (en_len > 0) begin
            if (!mon_skip) begin
                total_cnt++;
                if (en_len != DCT_CYCLES) $display("FAIL en_window: got %0d cycles want %0d", en_len, DCT_CYCLES);
                else pass_cnt++;
            end
            en_len = 0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        mon_skip = 1'b1;
        exp_q.delete();
        cur_n    = 0;
        exp_cnt  = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, output bit stalled);
        int g;
        g = 0;
        stalled = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        while (s_ready !== 1'b1 && g < 500) begin
            stalled = 1'b1;
            @(negedge clk);
            g++;
        end
        total_cnt++;
        if (g >= 500) $display("FAIL send_timeout: s_ready stuck at %b want 1", s_ready);
        else pass_cnt++;
        cur_frame[cur_n*8 +: 8] = exp_of(d);
        cur_n++;
        if (cur_n == 8) begin
            exp_q.push_back(cur_frame);
            cur_n = 0;
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((busy !== 1'b0 || exp_q.size() != 0) && g < 1000);
        total_cnt++;
        if (g >= 1000) $display("FAIL wait_idle: busy=%b pending=%0d want 0/0", busy, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready: got %b want 1", s_ready); else pass_cnt++;
        total_cnt++; if (en !== 1'b0 || cs !== 1'b0) $display("FAIL rst_en_cs: got %b/%b want 0/0", en, cs); else pass_cnt++;
        total_cnt++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start: got %b want 0", frame_start); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (frame_cnt !== '0) $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); else pass_cnt++;
        total_cnt++; if (lanes_now() !== 64'h0) $display("FAIL rst_lanes: got %h want 0", lanes_now()); else pass_cnt++;
    endtask

    task automatic test_single_frame();
        bit st;
        do_reset();
        for (int i = 1; i <= 8; i++) send(8'(i), st);
        total_cnt++; if (en !== 1'b0) $display("FAIL latency_early: en=%b want 0", en); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (en !== 1'b1) $display("FAIL latency_en: en=%b want 1", en); else pass_cnt++;
        total_cnt++;
        if (input0 !== exp_of(8'd1) || input7 !== exp_of(8'd8))
            $display("FAIL single_lanes: input0=%h input7=%h want %h %h", input0, input7, exp_of(8'd1), exp_of(8'd8));
        else pass_cnt++;
        wait_idle();
        total_cnt++; if (frame_cnt !== 4'd1) $display("FAIL single_cnt: got %0d want 1", frame_cnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit st;
        logic [23:0] stalls;
        stalls = '0;
        do_reset();
        fs_cyc.delete();
        for (int i = 0; i < 24; i++) begin
            send(8'(8'h10 + i), st);
            stalls[i] = st;
        end
        wait_idle();
        total_cnt++;
        if (stalls !== 24'h010000) $display("FAIL b2b_stalls: got %h want 010000", stalls); else pass_cnt++;
        total_cnt++;
        if (fs_cyc.size() != 3) $display("FAIL b2b_frames: got %0d want 3", fs_cyc.size());
        else if (fs_cyc[1] - fs_cyc[0] != DCT_CYCLES + 2 || fs_cyc[2] - fs_cyc[1] != DCT_CYCLES + 2)
            $display("FAIL b2b_period: got %0d,%0d want %0d", fs_cyc[1] - fs_cyc[0], fs_cyc[2] - fs_cyc[1], DCT_CYCLES + 2);
        else pass_cnt++;
    endtask

    task automatic test_gaps();
        bit st;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom_range(0, 255)), st);
            repeat (2) @(negedge clk);
        end
        wait_idle();
        total_cnt++; if (frame_cnt !== 4'd2) $display("FAIL gaps_cnt: got %0d want 2", frame_cnt); else pass_cnt++;
    endtask

    task automatic test_mid_run_reset();
        bit st;
        do_reset();
        for (int i = 0; i < 13; i++) send(8'(8'h20 + i), st);
        total_cnt++; if (en !== 1'b1) $display("FAIL midrst_in_run: en=%b want 1", en); else pass_cnt++;
        do_reset();
        total_cnt++; if (en !== 1'b0) $display("FAIL midrst_en: got %b want 0", en); else pass_cnt++;
        total_cnt++; if (frame_cnt !== '0) $display("FAIL midrst_cnt: got %0d want 0", frame_cnt); else pass_cnt++;
        for (int i = 0; i < 8; i++) send(8'(8'h50 + i), st);
        wait_idle();
        total_cnt++; if (frame_cnt !== 4'd1) $display("FAIL midrst_clean_cnt: got %0d want 1", frame_cnt); else pass_cnt++;
    endtask

    task automatic test_offset();
        bit st;
        logic [7:0] pat [8];
        pat = '{8'h80, 8'hFF, 8'h00, 8'h81, 8'h7F, 8'h01, 8'hC0, 8'h40};
        do_reset();
        for (int i = 0; i < 8; i++) send(pat[i], st);
        @(negedge clk);
        total_cnt++;
`ifdef FRAMER_OFFSET_BIN_EN
        if (input0 !== 8'h00 || input1 !== 8'h7F || input2 !== 8'h80 || input3 !== 8'h01)
            $display("FAIL offset_lanes: got %h %h %h %h want 00 7f 80 01", input0, input1, input2, input3);
`else
        if (input0 !== 8'h80 || input1 !== 8'hFF || input2 !== 8'h00 || input3 !== 8'h81)
            $display("FAIL raw_lanes: got %h %h %h %h want 80 ff 00 81", input0, input1, input2, input3);
`endif
        else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_wrap();
        bit st;
        do_reset();
        for (int f = 0; f < 17; f++)
            for (int k = 0; k < 8; k++) send(8'(f * 8 + k), st);
        wait_idle();
        total_cnt++; if (frame_cnt !== 4'd1) $display("FAIL wrap_cnt: got %0d want 1", frame_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gaps();
        test_mid_run_reset();
        test_offset();
        test_wrap();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
